audio_envelope_detector: RTL and testbench

Downstream stage of the audio controller: it consumes the 16-bit mono sample stream the controller presents on `raw_data` at each codec `advance` strobe. It computes a block-averaged absolute-value envelope and runs a hysteresis/hold-off state machine to detect sound events. It returns a packed 32-bit status word that the controller exposes to software through its `filtered_signal` read register.

---
 rtl/audio_envelope_detector.sv | 133 +++++++++++++
 tb/tb_audio_envelope_detector.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_envelope_detector.sv
// Block-averaged absolute-value envelope with a hysteresis/hold-off event detector.
// Produces the packed status word that software reads through filtered_signal.
module audio_envelope_detector #(
    parameter int          DATA_W      = 16,
    parameter int          WIN_LOG2    = 8,
    parameter logic [15:0] THRESH_ON   = 16'd4000,
    parameter logic [15:0] THRESH_OFF  = 16'd2000,
    parameter int          HOLDOFF_WIN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] raw_data,
    input  logic              clear,
    output logic [31:0]       filtered_signal,
    output logic              event_pulse
);

    localparam int ACC_W  = DATA_W + WIN_LOG2;
    localparam int HOLD_W = $clog2(HOLDOFF_WIN + 1);
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        HOLDOFF = 2'b10
    } state_t;

    logic [DATA_W-1:0]   abs_val;
    logic [DATA_W-1:0]   abs_r;
    logic                valid_r;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [DATA_W-1:0]   level_r;
    logic                win_done;
    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [7:0]          event_count;
    logic [15:0]         shown_level;

    // Most negative code has no positive twin, so it saturates to full scale.
    always_comb begin
        abs_val = raw_data;
        if (raw_data[DATA_W-1]) begin
            abs_val = (raw_data == S_MIN) ? S_MAX : (~raw_data + 1'b1);
        end
    end

    assign acc_sum = acc + ACC_W'(abs_r);

    // NOTE: every register here is plain control/datapath state (no memory array), so all of it takes the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abs_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= sample_valid;
            if (sample_valid) begin
                abs_r <= abs_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            win_cnt  <= '0;
            level_r  <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (valid_r) begin
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == '1) begin
                    level_r  <= acc_sum[ACC_W-1:WIN_LOG2];
                    acc      <= '0;
                    win_done <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            event_count <= '0;
            shown_level <= '0;
            event_pulse <= 1'b0;
        end else begin
            event_pulse <= 1'b0;
            if (win_done) begin
                shown_level <= level_r;
                case (state)
                    IDLE: begin
                        if (level_r >= THRESH_ON) begin
                            state       <= ACTIVE;
                            event_count <= event_count + 1'b1;
                            event_pulse <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (level_r < THRESH_OFF) begin
                            state    <= HOLDOFF;
                            hold_cnt <= HOLD_W'(HOLDOFF_WIN);
                        end
                    end
                    HOLDOFF: begin
                        // The window that ends hold-off is not checked against THRESH_ON.
                        if (hold_cnt == HOLD_W'(1)) begin
                            state <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // NOTE: the last non-blocking assignment wins, so clear overrides a same-edge increment.
            if (clear) begin
                event_count <= '0;
            end
        end
    end

    // All fields are registers that only move together at E2 (or on clear), so the word stays coherent.
    assign filtered_signal = {event_count, 6'b0, state, shown_level};

endmodule

// File: tb/tb_audio_envelope_detector.sv
// Scoreboard bench for audio_envelope_detector: a behavioural model predicts each
// window's status word and pulse, and a negedge monitor compares them at E2.
module tb_audio_envelope_detector;

    localparam int WIN_LOG2    = 8;
    localparam int WIN         = 1 << WIN_LOG2;
    localparam int HOLDOFF_WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] raw_data = '0;
    logic [31:0] filtered_signal;
    logic        event_pulse;
    logic [31:0] fs_w;
    logic        pulse_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_seen = 0;
    int pulse_w_seen = 0;
    int mon_pops = 0;

    typedef struct {
        int          due;
        logic [31:0] word;
        logic        pulse;
    } sb_entry_t;

    sb_entry_t sb[$];

    int          m_acc, m_cnt, m_st, m_hold, m_count;
    logic [31:0] m_last_word;

    audio_envelope_detector dut (
        .clk            (clk),
        .reset          (rst_n),
        .sample_valid   (sample_valid),
        .raw_data       (raw_data),
        .clear          (clear),
        .filtered_signal(filtered_signal),
        .event_pulse    (event_pulse)
    );

    // Tiny windows with a one-window hold-off make the 256-event wrap affordable.
    audio_envelope_detector #(.WIN_LOG2(1), .HOLDOFF_WIN(1)) dut_w (
        .clk            (clk),
        .reset          (rst_n),
        .sample_valid   (sample_valid),
        .raw_data       (raw_data),
        .clear          (clear),
        .filtered_signal(fs_w),
        .event_pulse    (pulse_w)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sb_entry_t mon_e;
    logic      mon_exp_pulse;

    always @(negedge clk) begin
        mon_exp_pulse = 1'b0;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missed due %0d now %0d want word %h", mon_e.due, cyc, mon_e.word);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            mon_pops++;
            mon_exp_pulse = mon_e.pulse;
            checks++;
            if (filtered_signal !== mon_e.word) begin
                errors++;
                $display("FAIL sb_word cyc %0d got %h want %h", cyc, filtered_signal, mon_e.word);
            end
        end
        checks++;
        if (event_pulse !== mon_exp_pulse) begin
            errors++;
            $display("FAIL sb_pulse cyc %0d got %b want %b", cyc, event_pulse, mon_exp_pulse);
        end
        if (event_pulse === 1'b1) pulse_seen++;
        if (pulse_w === 1'b1) pulse_w_seen++;
    end

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_st = 0; m_hold = 0; m_count = 0;
        m_last_word = '0;
        sb.delete();
    endtask

    task automatic model_window(input int lvl, input int due);
        sb_entry_t e;
        logic      p;
        p = 1'b0;
        case (m_st)
            0: if (lvl >= 4000) begin m_st = 1; m_count = (m_count + 1) % 256; p = 1'b1; end
            1: if (lvl < 2000) begin m_st = 2; m_hold = HOLDOFF_WIN; end
            default: if (m_hold == 1) m_st = 0; else m_hold = m_hold - 1;
        endcase
        e.due   = due;
        e.word  = {8'(m_count), 6'b0, 2'(m_st), 16'(lvl)};
        e.pulse = p;
        sb.push_back(e);
        m_last_word = e.word;
    endtask

    // One clock slot: inputs change 1 unit after posedge and are captured on the next posedge.
    task automatic slot(input logic v, input int data, input logic clr);
        int        k, a;
        sb_entry_t e;
        @(posedge clk);
        #1;
        k = cyc;
        sample_valid = v;
        raw_data     = 16'(data);
        clear        = clr;
        if (v) begin
            a = (data == -32768) ? 32767 : ((data < 0) ? -data : data);
            m_acc = m_acc + a;
            m_cnt = m_cnt + 1;
            if (m_cnt == WIN) begin
                model_window(m_acc >> WIN_LOG2, k + 3);
                m_acc = 0;
                m_cnt = 0;
            end
        end
        if (clr) begin
            m_count = 0;
            if (sb.size() > 0 && sb[sb.size()-1].due == k + 1) begin
                e = sb.pop_back();
                e.word[31:24] = 8'h00;
                sb.push_back(e);
            end else begin
                e.due   = k + 1;
                e.word  = {8'h00, m_last_word[23:0]};
                e.pulse = 1'b0;
                sb.push_back(e);
            end
            m_last_word[31:24] = 8'h00;
        end
    endtask

    task automatic feed_window(input int val, input int gap);
        for (int i = 0; i < WIN; i++) begin
            slot(1'b1, val, 1'b0);
            for (int g = 0; g < gap; g++) slot(1'b0, 0, 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 32) begin
            slot(1'b0, 0, 1'b0);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        clear = 1'b0;
        raw_data = '0;
        model_reset();
        #2;
        checks++;
        if (filtered_signal !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_word got %h want 00000000", filtered_signal);
        end
        checks++;
        if (event_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_pulse got %b want 0", event_pulse);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) slot(1'b0, 0, 1'b0);
        checks++;
        if (filtered_signal !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle_word got %h want 00000000", filtered_signal);
        end
    endtask

    task automatic test_basic_detection();
        int p0;
        do_reset();
        p0 = pulse_seen;
        // Three idle cycles between strobes stand in for the much sparser codec rate.
        feed_window(5000, 3);
        drain();
        checks++;
        if (filtered_signal !== 32'h0101_1388) begin
            errors++;
            $display("FAIL basic_word got %h want 01011388", filtered_signal);
        end
        checks++;
        if (pulse_seen - p0 !== 1) begin
            errors++;
            $display("FAIL basic_pulses got %0d want 1", pulse_seen - p0);
        end
    endtask

    task automatic test_saturation_sign();
        int p0;
        do_reset();
        feed_window(-32768, 0);
        drain();
        checks++;
        if (filtered_signal !== 32'h0101_7FFF) begin
            errors++;
            $display("FAIL sat_word got %h want 01017fff", filtered_signal);
        end
        do_reset();
        p0 = pulse_seen;
        for (int i = 0; i < WIN; i++) slot(1'b1, (i % 2 == 0) ? 1000 : -1000, 1'b0);
        drain();
        checks++;
        if (filtered_signal !== 32'h0000_03E8) begin
            errors++;
            $display("FAIL alt_word got %h want 000003e8", filtered_signal);
        end
        checks++;
        if (pulse_seen - p0 !== 0) begin
            errors++;
            $display("FAIL alt_pulses got %0d want 0", pulse_seen - p0);
        end
    endtask

    task automatic test_hysteresis();
        int          lv[8];
        logic [31:0] want[8];
        int          p0;
        lv   = '{5000, 3000, 1000, 5000, 5000, 5000, 5000, 5000};
        want = '{32'h0101_1388, 32'h0101_0BB8, 32'h0102_03E8, 32'h0102_1388,
                 32'h0102_1388, 32'h0102_1388, 32'h0100_1388, 32'h0201_1388};
        do_reset();
        p0 = pulse_seen;
        for (int w = 0; w < 8; w++) begin
            feed_window(lv[w], 0);
            drain();
            checks++;
            if (filtered_signal !== want[w]) begin
                errors++;
                $display("FAIL hyst_win%0d got %h want %h", w, filtered_signal, want[w]);
            end
        end
        checks++;
        if (pulse_seen - p0 !== 2) begin
            errors++;
            $display("FAIL hyst_pulses got %0d want 2", pulse_seen - p0);
        end
    endtask

    task automatic test_thresholds_exact();
        int          lv[4];
        logic [31:0] want[4];
        lv   = '{3999, 4000, 2000, 1999};
        want = '{32'h0000_0F9F, 32'h0101_0FA0, 32'h0101_07D0, 32'h0102_07CF};
        do_reset();
        for (int w = 0; w < 4; w++) begin
            feed_window(lv[w], 0);
            drain();
            checks++;
            if (filtered_signal !== want[w]) begin
                errors++;
                $display("FAIL thresh_win%0d got %h want %h", w, filtered_signal, want[w]);
            end
        end
    endtask

    task automatic test_clear();
        int p0;
        slot(1'b0, 0, 1'b1);
        drain();
        checks++;
        if (filtered_signal !== 32'h0002_07CF) begin
            errors++;
            $display("FAIL clear_quiet got %h want 000207cf", filtered_signal);
        end
        do_reset();
        p0 = pulse_seen;
        feed_window(5000, 0);
        slot(1'b0, 0, 1'b0);
        slot(1'b0, 0, 1'b1);
        drain();
        checks++;
        if (filtered_signal !== 32'h0001_1388) begin
            errors++;
            $display("FAIL clear_coincide got %h want 00011388", filtered_signal);
        end
        checks++;
        if (pulse_seen - p0 !== 1) begin
            errors++;
            $display("FAIL clear_coincide_pulse got %0d want 1", pulse_seen - p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, w0;
        do_reset();
        p0 = pulse_seen;
        w0 = mon_pops;
        for (int i = 0; i < 4 * WIN; i++) slot(1'b1, 6000, 1'b0);
        drain();
        checks++;
        if (filtered_signal !== 32'h0101_1770) begin
            errors++;
            $display("FAIL b2b_word got %h want 01011770", filtered_signal);
        end
        checks++;
        if (mon_pops - w0 !== 4) begin
            errors++;
            $display("FAIL b2b_windows got %0d want 4", mon_pops - w0);
        end
        checks++;
        if (pulse_seen - p0 !== 1) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 1", pulse_seen - p0);
        end
        for (int i = 0; i < 100; i++) slot(1'b1, 30000, 1'b0);
        do_reset();
        feed_window(5000, 0);
        drain();
        checks++;
        if (filtered_signal !== 32'h0101_1388) begin
            errors++;
            $display("FAIL midreset_word got %h want 01011388", filtered_signal);
        end
    endtask

    task automatic test_counter_wrap();
        int p0;
        do_reset();
        p0 = pulse_w_seen;
        for (int g = 0; g < 256; g++) begin
            slot(1'b1, 5000, 1'b0);
            slot(1'b1, 5000, 1'b0);
            for (int z = 0; z < 4; z++) slot(1'b1, 0, 1'b0);
            if (g == 254) begin
                checks++;
                if (fs_w[31:24] !== 8'hFF) begin
                    errors++;
                    $display("FAIL wrap_255 got %h want ff", fs_w[31:24]);
                end
            end
        end
        checks++;
        if (fs_w[31:24] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_256 got %h want 00", fs_w[31:24]);
        end
        checks++;
        if (pulse_w_seen - p0 !== 256) begin
            errors++;
            $display("FAIL wrap_pulses got %0d want 256", pulse_w_seen - p0);
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic_detection();
        test_saturation_sign();
        test_hysteresis();
        test_thresholds_exact();
        test_clear();
        test_back_to_back();
        test_counter_wrap();
        repeat (4) slot(1'b0, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
